sum_window_accum: RTL and testbench
===================================

Name: sum_window_accum

Overview:
Downstream consumer of the 8-bit combinational sum stage. It takes the stage's sum output (A_in + B_in, carried as an 8-bit value) one sample per handshake and accumulates WIN_LEN samples into a wide saturating sum. It then presents the window total on a valid/ready output and holds it until the consumer accepts it. It is the first registered stage after the adder path.

Parameters:
DATA_W, 8, width of incoming sample (matches upstream Z_out)
WIN_LEN, 4, samples per window; legal range 1..255
ACC_W, 16, accumulator/result width; must be >= DATA_W

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
Z_in  input  DATA_W  sample from upstream sum stage
z_valid_in  input  1  sample on Z_in is valid
z_ready_out  output  1  block can accept a sample this cycle
clear_in  input  1  synchronous window abort; discards partial window
sum_out  output  ACC_W  window total, saturated
sum_valid_out  output  1  sum_out holds a completed window
sum_ready_in  input  1  downstream accepts sum_out
count_out  output  8  samples accepted in current window
overflow_out  output  1  current/held window saturated (sticky per window)

Behaviour:
- Reset (rst_n=0, async assert, sync-release use): state=IDLE; acc, sum_out, count_out=0; sum_valid_out=0; overflow_out=0; z_ready_out=1 after reset releases.
- States: IDLE (no samples yet), ACCUM (1..WIN_LEN-1 samples taken), HOLD (window complete, output pending).
- z_ready_out = 1 in IDLE/ACCUM, 0 in HOLD. Combinational from state only, not from z_valid_in.
- Accept = z_valid_in && z_ready_out.
- On accept: acc <= sat(acc + zero-extended Z_in); count_out increments.
- Transitions: IDLE->ACCUM on accept. IDLE->HOLD on accept when WIN_LEN=1. ACCUM->HOLD on the accept that makes count = WIN_LEN.
- Entering HOLD: sum_out <= final saturated acc, sum_valid_out <= 1 on the next cycle. Latency is 1 cycle from the last accepted sample to sum_valid_out=1.
- HOLD: sum_out, overflow_out and count_out (=WIN_LEN) stable while sum_valid_out && !sum_ready_in.
- HOLD->IDLE on sum_ready_in: the next cycle has sum_valid_out=0, acc=0, count_out=0, overflow_out=0.
- No sample is accepted in the handoff cycle; z_ready_out rises the cycle after.
- Saturation: if acc + Z_in > 2^ACC_W-1, acc <= 2^ACC_W-1 and overflow_out <= 1. Once saturated, acc stays at max for the rest of the window.
- clear_in (IDLE/ACCUM): acc, count_out, overflow_out <= 0; state <= IDLE. A sample offered in the same cycle is consumed and discarded (clear wins).
- clear_in in HOLD: ignored. A completed window is never dropped.
- sum_ready_in while sum_valid_out=0: no effect.
- Async reset mid-window or mid-HOLD: all state cleared immediately; the partial or held window is lost.
- count_out is 8 bits regardless of WIN_LEN.

Test Plan:
- Basic window: WIN_LEN=4, Z_in=10,20,30,40 back-to-back valid, sum_ready_in=1 -> sum_valid_out=1 one cycle after 4th accept, sum_out=100, overflow_out=0, then IDLE with count_out=0.
- Backpressure: window of 4x0xFF with sum_ready_in=0 for 5 cycles -> sum_out=1020 held stable, z_ready_out=0 throughout, z_valid_in samples not consumed; release -> handoff, z_ready_out=1 next cycle.
- Saturation: ACC_W=9, WIN_LEN=4, Z_in=0xFF x4 -> sum_out=511, overflow_out=1; the next window of 1,1,1,1 -> sum_out=4, overflow_out=0.
- Clear: accept 5,6, then clear_in=1 with z_valid_in=1, Z_in=7 -> count_out=0; the following 4 samples of 1 -> sum_out=4. clear_in during HOLD -> sum_out unchanged.
- Gapped valid: WIN_LEN=3, Z_in=1,2,3 with 2 idle cycles between each -> sum_out=6, count_out steps 1,2,3.
- Async reset: assert rst_n=0 mid-cycle after 2 accepts and again during HOLD -> outputs 0 immediately without a clock edge; a fresh window of 4x2 afterwards -> sum_out=8.

Source files
------------

// File: rtl/sum_window_accum.sv
// Windowed saturating accumulator fed by the 8-bit sum stage: collects WIN_LEN
// samples, then holds the window total on a valid/ready output until accepted.
module sum_window_accum #(
    parameter int DATA_W  = 8,
    parameter int WIN_LEN = 4,
    parameter int ACC_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] Z_in,
    input  logic              z_valid_in,
    output logic              z_ready_out,
    input  logic              clear_in,
    output logic [ACC_W-1:0]  sum_out,
    output logic              sum_valid_out,
    input  logic              sum_ready_in,
    output logic [7:0]        count_out,
    output logic              overflow_out
);

    // Handshakes: a transfer happens on a rising edge where valid && ready.
    // Valid never depends on ready; z_ready_out depends on state only.

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t             state;
    logic [ACC_W-1:0]   acc;

    logic               accept;
    logic [ACC_W:0]     sum_wide;
    logic               sat;
    logic [ACC_W-1:0]   acc_next;
    logic [8:0]         count_inc;
    logic               last_sample;

    assign z_ready_out = (state != HOLD);
    assign accept      = z_valid_in && z_ready_out;

    // One extra bit catches the carry that signals saturation.
    assign sum_wide    = {1'b0, acc} + {{(ACC_W + 1 - DATA_W){1'b0}}, Z_in};
    assign sat         = sum_wide[ACC_W];
    assign acc_next    = sat ? {ACC_W{1'b1}} : sum_wide[ACC_W-1:0];
    assign count_inc   = {1'b0, count_out} + 9'd1;
    assign last_sample = (count_inc == 9'(WIN_LEN));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            acc           <= '0;
            sum_out       <= '0;
            sum_valid_out <= 1'b0;
            count_out     <= '0;
            overflow_out  <= 1'b0;
        end else begin
            case (state)
                IDLE, ACCUM: begin
                    if (clear_in) begin
                        // Clear wins over a sample offered in the same cycle.
                        acc          <= '0;
                        count_out    <= '0;
                        overflow_out <= 1'b0;
                        state        <= IDLE;
                    end else if (accept) begin
                        acc          <= acc_next;
                        count_out    <= count_inc[7:0];
                        overflow_out <= overflow_out | sat;
                        if (last_sample) begin
                            sum_out       <= acc_next;
                            sum_valid_out <= 1'b1;
                            state         <= HOLD;
                        end else begin
                            state <= ACCUM;
                        end
                    end
                end
                HOLD: begin
                    // Clear is ignored here so a completed window is never lost.
                    if (sum_ready_in) begin
                        sum_valid_out <= 1'b0;
                        acc           <= '0;
                        count_out     <= '0;
                        overflow_out  <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sum_window_accum.sv
// Directed bench for sum_window_accum: three instances cover the default,
// narrow-accumulator and three-sample-window configurations.
module tb_sum_window_accum;

    logic        clk;
    logic        rst_n;
    logic [7:0]  z_in;
    logic        z_valid;
    logic        clear;
    logic        sum_ready;
    logic [1:0]  sel;

    logic [2:0]  vld;
    logic [2:0]  clr;
    logic [2:0]  rdy;
    logic [2:0]  sv;
    logic [2:0]  ovf;
    logic [15:0] sum0;
    logic [8:0]  sum1;
    logic [15:0] sum2;
    logic [7:0]  cnt0;
    logic [7:0]  cnt1;
    logic [7:0]  cnt2;

    int checks;
    int errors;

    assign vld[0] = z_valid && (sel == 2'd0);
    assign vld[1] = z_valid && (sel == 2'd1);
    assign vld[2] = z_valid && (sel == 2'd2);
    assign clr[0] = clear && (sel == 2'd0);
    assign clr[1] = clear && (sel == 2'd1);
    assign clr[2] = clear && (sel == 2'd2);

    sum_window_accum #(.DATA_W(8), .WIN_LEN(4), .ACC_W(16)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .Z_in(z_in), .z_valid_in(vld[0]),
        .z_ready_out(rdy[0]), .clear_in(clr[0]), .sum_out(sum0),
        .sum_valid_out(sv[0]), .sum_ready_in(sum_ready), .count_out(cnt0),
        .overflow_out(ovf[0])
    );

    sum_window_accum #(.DATA_W(8), .WIN_LEN(4), .ACC_W(9)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .Z_in(z_in), .z_valid_in(vld[1]),
        .z_ready_out(rdy[1]), .clear_in(clr[1]), .sum_out(sum1),
        .sum_valid_out(sv[1]), .sum_ready_in(sum_ready), .count_out(cnt1),
        .overflow_out(ovf[1])
    );

    sum_window_accum #(.DATA_W(8), .WIN_LEN(3), .ACC_W(16)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .Z_in(z_in), .z_valid_in(vld[2]),
        .z_ready_out(rdy[2]), .clear_in(clr[2]), .sum_out(sum2),
        .sum_valid_out(sv[2]), .sum_ready_in(sum_ready), .count_out(cnt2),
        .overflow_out(ovf[2])
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Outputs are sampled 1 ns after the rising edge; inputs change there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int unsigned v);
        z_in    = v[7:0];
        z_valid = 1'b1;
        tick();
        z_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        z_in      = '0;
        z_valid   = 1'b0;
        clear     = 1'b0;
        sum_ready = 1'b1;
        sel       = 2'd0;

        // Reset state
        #12;
        check("rst_sum", 32'(sum0), 0);
        check("rst_valid", 32'(sv[0]), 0);
        check("rst_count", 32'(cnt0), 0);
        check("rst_ovf", 32'(ovf[0]), 0);
        rst_n = 1'b1;
        tick();
        check("rst_ready", 32'(rdy[0]), 1);

        // Basic window 10+20+30+40
        send(10);
        check("basic_cnt1", 32'(cnt0), 1);
        send(20);
        send(30);
        check("basic_cnt3", 32'(cnt0), 3);
        check("basic_nv3", 32'(sv[0]), 0);
        send(40);
        check("basic_valid", 32'(sv[0]), 1);
        check("basic_sum", 32'(sum0), 100);
        check("basic_ovf", 32'(ovf[0]), 0);
        check("basic_cnt4", 32'(cnt0), 4);
        check("basic_rdy_hold", 32'(rdy[0]), 0);
        tick();
        check("basic_done_v", 32'(sv[0]), 0);
        check("basic_done_cnt", 32'(cnt0), 0);
        check("basic_done_rdy", 32'(rdy[0]), 1);

        // Backpressure: held window must not absorb offered samples
        sum_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(8'hFF);
        check("bp_valid", 32'(sv[0]), 1);
        check("bp_sum", 32'(sum0), 1020);
        z_in    = 8'h55;
        z_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_hold_sum", 32'(sum0), 1020);
            check("bp_hold_rdy", 32'(rdy[0]), 0);
            check("bp_hold_cnt", 32'(cnt0), 4);
            check("bp_hold_v", 32'(sv[0]), 1);
        end
        sum_ready = 1'b1;
        tick();
        check("bp_hand_v", 32'(sv[0]), 0);
        check("bp_hand_cnt", 32'(cnt0), 0);
        check("bp_hand_rdy", 32'(rdy[0]), 1);
        z_valid = 1'b0;
        tick();
        check("bp_after_cnt", 32'(cnt0), 0);

        // Saturation on the 9-bit accumulator: 255,510,511(sat),511
        sel = 2'd1;
        send(8'hFF);
        send(8'hFF);
        check("sat_pre_ovf", 32'(ovf[1]), 0);
        send(8'hFF);
        check("sat_mid_ovf", 32'(ovf[1]), 1);
        send(8'hFF);
        check("sat_sum", 32'(sum1), 511);
        check("sat_ovf", 32'(ovf[1]), 1);
        check("sat_valid", 32'(sv[1]), 1);
        tick();
        check("sat_hand_ovf", 32'(ovf[1]), 0);
        for (int i = 0; i < 4; i++) send(1);
        check("sat_next_sum", 32'(sum1), 4);
        check("sat_next_ovf", 32'(ovf[1]), 0);
        tick();

        // Clear mid-window, then clear during HOLD
        sel = 2'd0;
        sum_ready = 1'b0;
        send(5);
        send(6);
        check("clr_cnt2", 32'(cnt0), 2);
        clear = 1'b1;
        send(7);
        clear = 1'b0;
        check("clr_cnt0", 32'(cnt0), 0);
        check("clr_rdy", 32'(rdy[0]), 1);
        for (int i = 0; i < 4; i++) send(1);
        check("clr_sum", 32'(sum0), 4);
        check("clr_valid", 32'(sv[0]), 1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clr_hold_sum", 32'(sum0), 4);
        check("clr_hold_v", 32'(sv[0]), 1);
        check("clr_hold_cnt", 32'(cnt0), 4);
        sum_ready = 1'b1;
        tick();
        check("clr_hand_v", 32'(sv[0]), 0);

        // Gapped samples into the 3-sample window
        sel = 2'd2;
        sum_ready = 1'b0;
        send(1);
        check("gap_cnt1", 32'(cnt2), 1);
        idle(2);
        check("gap_cnt1_hold", 32'(cnt2), 1);
        send(2);
        check("gap_cnt2", 32'(cnt2), 2);
        idle(2);
        send(3);
        check("gap_cnt3", 32'(cnt2), 3);
        check("gap_sum", 32'(sum2), 6);
        check("gap_valid", 32'(sv[2]), 1);
        sum_ready = 1'b1;
        tick();
        check("gap_hand_v", 32'(sv[2]), 0);

        // Async reset mid-window
        sel = 2'd0;
        send(3);
        send(3);
        check("ar_cnt2", 32'(cnt0), 2);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_mid_cnt", 32'(cnt0), 0);
        check("ar_mid_sum", 32'(sum0), 0);
        check("ar_mid_rdy", 32'(rdy[0]), 1);
        rst_n = 1'b1;
        tick();

        // Async reset during HOLD
        sum_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(2);
        check("ar_hold_sum", 32'(sum0), 8);
        check("ar_hold_v", 32'(sv[0]), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_hold_rst_v", 32'(sv[0]), 0);
        check("ar_hold_rst_sum", 32'(sum0), 0);
        check("ar_hold_rst_cnt", 32'(cnt0), 0);
        check("ar_hold_rst_ovf", 32'(ovf[0]), 0);
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) send(2);
        check("ar_fresh_sum", 32'(sum0), 8);
        check("ar_fresh_v", 32'(sv[0]), 1);
        sum_ready = 1'b1;
        tick();
        check("ar_fresh_hand", 32'(sv[0]), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
